// File: rtl/coproc_io_bridge.sv
// Host-side request queue and sequencer driving the core's coprocessor IO port.
// Optional core-halt output is built only when COPROC_HALT_EN is defined.
module coproc_io_bridge #(
    parameter int N          = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int READ_LAT   = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [14:0]   req_addr,
    input  logic [N-1:0]  req_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [N-1:0]  rsp_data,
    output logic [14:0]   io_addr,
    output logic [3:0]    io_control,
    output logic [N-1:0]  io_dataOut,
    input  logic [N-1:0]  io_dataIn
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = AW + 1;
    localparam logic [1:0] LAT_INIT = 2'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [PW-1:0]  wr_ptr_next_s;
    logic [PW-1:0]  rd_ptr_next_s;
    logic           empty_s;
    logic           full_next_s;
    logic           push_s;
    logic           pop_s;
    logic [14:0]    addr_mem_r  [FIFO_DEPTH];
    logic [N-1:0]   data_mem_r  [FIFO_DEPTH];
    logic           write_mem_r [FIFO_DEPTH];
    logic [1:0]     lat_cnt_r;
    logic [1:0]     strobe_r;
    logic [14:0]    io_addr_r;
    logic [N-1:0]   io_dout_r;
    logic           rsp_valid_r;
    logic [N-1:0]   rsp_data_r;
    logic           req_ready_r;

    // req_ready is registered, so a same-cycle pop never frees room for this cycle's push
    assign push_s  = req_valid && req_ready_r;
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign pop_s   = (state_r == IDLE) && !empty_s;

    // Next pointer values and the full flag they imply
    always_comb begin
        wr_ptr_next_s = wr_ptr_r + {{AW{1'b0}}, push_s};
        rd_ptr_next_s = rd_ptr_r + {{AW{1'b0}}, pop_s};
        full_next_s   = (wr_ptr_next_s[AW] != rd_ptr_next_s[AW]) &&
                        (wr_ptr_next_s[AW-1:0] == rd_ptr_next_s[AW-1:0]);
    end

    // Queue storage; contents are don't-care until pointed at
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_mem_r[wr_ptr_r[AW-1:0]]  <= req_addr;
            data_mem_r[wr_ptr_r[AW-1:0]]  <= req_data;
            write_mem_r[wr_ptr_r[AW-1:0]] <= req_write;
        end
    end

    // Sequencer next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                if (strobe_r[1]) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_r == 2'd0) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, pointers and host-facing handshake registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            wr_ptr_r    <= wr_ptr_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            req_ready_r <= !full_next_s;
            rsp_valid_r <= (state_next_s == RESP);
        end
    end

    // IO port registers: loaded from the queue head on pop, strobes live only in ISSUE
    always_ff @(posedge clk) begin
        if (!reset) begin
            strobe_r  <= 2'b00;
            io_addr_r <= 15'd0;
            io_dout_r <= {N{1'b0}};
        end else if (pop_s) begin
            io_addr_r <= addr_mem_r[rd_ptr_r[AW-1:0]];
            if (write_mem_r[rd_ptr_r[AW-1:0]]) begin
                strobe_r  <= 2'b10;
                io_dout_r <= data_mem_r[rd_ptr_r[AW-1:0]];
            end else begin
                strobe_r  <= 2'b01;
            end
        end else begin
            strobe_r <= 2'b00;
        end
    end

    // Read latency counter and response capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_cnt_r  <= 2'd0;
            rsp_data_r <= {N{1'b0}};
        end else begin
            if (state_r == ISSUE) begin
                lat_cnt_r <= LAT_INIT;
            end else if ((state_r == WAIT) && (lat_cnt_r != 2'd0)) begin
                lat_cnt_r <= lat_cnt_r - 2'd1;
            end
            if ((state_r == WAIT) && (lat_cnt_r == 2'd0)) begin
                rsp_data_r <= io_dataIn;
            end
        end
    end

`ifdef COPROC_HALT_EN
    logic halt_r;

    // Hold the core halted while anything is queued or in flight, one cycle behind
    always_ff @(posedge clk) begin
        if (!reset) begin
            halt_r <= 1'b0;
        end else begin
            halt_r <= !empty_s || (state_r != IDLE);
        end
    end

    assign io_control = {1'b0, halt_r, strobe_r};
`else
    assign io_control = {2'b00, strobe_r};
`endif

    assign req_ready  = req_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_data   = rsp_data_r;
    assign io_addr    = io_addr_r;
    assign io_dataOut = io_dout_r;

endmodule

// File: tb/tb_coproc_io_bridge.sv
// Self-checking bench for coproc_io_bridge: directed table, corner sequences and
// randomized traffic against a transaction-level queue model.
module tb_coproc_io_bridge;

    localparam int N     = 64;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;
`ifdef COPROC_HALT_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [14:0]   req_addr = 15'd0;
    logic [N-1:0]  req_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [N-1:0]  rsp_data;
    logic [14:0]   io_addr;
    logic [3:0]    io_control;
    logic [N-1:0]  io_dataOut;
    logic [N-1:0]  io_dataIn = '0;

    coproc_io_bridge #(.N(N), .FIFO_DEPTH(DEPTH), .READ_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .io_addr(io_addr), .io_control(io_control), .io_dataOut(io_dataOut),
        .io_dataIn(io_dataIn)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [14:0] addr;
        logic [63:0] data;
        int          cyc;
    } req_t;

    typedef struct {
        logic [14:0] addr;
        logic [63:0] data;
        int          cyc;
    } wlog_t;

    typedef struct {
        bit          wr;
        logic [14:0] addr;
        logic [63:0] data;
        logic [63:0] core;
        logic [3:0]  ctrl;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    req_t        pend_q[$];
    logic [63:0] exp_rsp_q[$];
    wlog_t       wr_log[$];
    bit          read_busy = 1'b0;
    int          sample_cycle = 0;
    logic [14:0] last_addr = 15'd0;
    logic [63:0] last_wdata = '0;
    bit          prev_valid = 1'b0;
    logic [63:0] prev_data = '0;
    bit          busy_prev = 1'b0;
    bit          force_en = 1'b0;
    logic [63:0] force_din = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One clock cycle: model the edge from the pre-edge inputs, then check the outputs
    task automatic tick();
        bit          pre_rst, pre_push, pre_hs, busy_now;
        req_t        ent, e;
        logic [1:0]  st;
        logic [63:0] v;
        pre_rst  = (reset == 1'b0);
        pre_push = !pre_rst && req_valid && req_ready;
        pre_hs   = !pre_rst && rsp_valid && rsp_ready;
        ent      = '{req_write, req_addr, req_data, 0};
        if (pre_hs) begin
            if (exp_rsp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
            else chk("rsp_data", rsp_data, exp_rsp_q.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pre_rst) begin
            pend_q.delete();
            exp_rsp_q.delete();
            read_busy  = 1'b0;
            last_addr  = 15'd0;
            last_wdata = '0;
            busy_prev  = 1'b0;
            chk("rst_req_ready", req_ready, 64'd0);
            chk("rst_rsp_valid", rsp_valid, 64'd0);
            chk("rst_rsp_data", rsp_data, 64'd0);
            chk("rst_io_control", io_control, 64'd0);
            chk("rst_io_addr", io_addr, 64'd0);
            chk("rst_io_dataOut", io_dataOut, 64'd0);
        end else begin
            if (pre_push) begin
                ent.cyc = cyc;
                pend_q.push_back(ent);
            end
            if (pre_hs) read_busy = 1'b0;
            st = io_control[1:0];
            if (st != 2'b00) begin
                if (pend_q.size() == 0) begin
                    chk("issue_empty_queue", 64'd1, 64'd0);
                end else begin
                    e = pend_q.pop_front();
                    chk("issue_kind", st, e.wr ? 64'd2 : 64'd1);
                    chk("issue_addr", io_addr, e.addr);
                    chk("issue_no_bypass", 64'(e.cyc < cyc), 64'd1);
                    chk("issue_during_read", read_busy, 64'd0);
                    last_addr = e.addr;
                    if (e.wr) begin
                        chk("issue_wdata", io_dataOut, e.data);
                        last_wdata = e.data;
                        wr_log.push_back('{e.addr, e.data, cyc});
                    end else begin
                        read_busy    = 1'b1;
                        sample_cycle = cyc + LAT;
                    end
                end
            end else begin
                chk("hold_io_addr", io_addr, last_addr);
                chk("hold_io_dataOut", io_dataOut, last_wdata);
            end
            chk("req_ready", req_ready, 64'(pend_q.size() != DEPTH));
            chk("rsp_valid", rsp_valid, 64'(read_busy && (cyc > sample_cycle)));
            if (rsp_valid && prev_valid && !pre_hs) chk("rsp_hold", rsp_data, prev_data);
            chk("ctrl_bit3", io_control[3], 64'd0);
            chk("halt", io_control[2], HALT ? 64'(busy_prev) : 64'd0);
            busy_now  = (pend_q.size() != 0) || (st != 2'b00) || read_busy;
            busy_prev = busy_now;
        end
        prev_valid = rsp_valid;
        prev_data  = rsp_data;
        if (!pre_rst && read_busy && (cyc == sample_cycle)) begin
            v = force_en ? force_din : rnd64();
            exp_rsp_q.push_back(v);
            io_dataIn = v;
        end else begin
            io_dataIn = rnd64();
        end
    endtask

    task automatic push_one(input bit w, input logic [14:0] a, input logic [63:0] d);
        bit acc;
        acc       = 1'b0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_data  = d;
        for (int k = 0; k < 40 && !acc; k++) begin
            acc = req_ready;
            tick();
        end
        req_valid = 1'b0;
        chk("push_accept", acc, 64'd1);
    endtask

    vec_t        tbl[5];
    logic [14:0] fa[5];
    logic [63:0] fd[5];

    initial begin
        bit found;
        int sc;
        tbl[0] = '{1'b1, 15'h0340, 64'h0000_0000_0000_DEAD, 64'd0, 4'b0010};
        tbl[1] = '{1'b0, 15'h0300, 64'd0, 64'h0000_0000_0000_1234, 4'b0001};
        tbl[2] = '{1'b1, 15'h7FFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'b0010};
        tbl[3] = '{1'b0, 15'h0000, 64'd0, 64'hA5A5_5A5A_0F0F_F0F0, 4'b0001};
        tbl[4] = '{1'b0, 15'h4001, 64'd0, 64'h8000_0000_0000_0001, 4'b0001};

        // Reset state
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        tick();
        chk("post_reset_ready", req_ready, 64'd1);
        rsp_ready = 1'b1;

        // Single transactions from idle
        for (int i = 0; i < 5; i++) begin
            push_one(tbl[i].wr, tbl[i].addr, tbl[i].data);
            found = 1'b0;
            for (int k = 0; k < 10 && !found; k++) begin
                if (io_control[1:0] != 2'b00) found = 1'b1;
                else tick();
            end
            chk("tbl_strobe_seen", found, 64'd1);
            chk("tbl_ctrl", io_control, {tbl[i].ctrl[3], HALT, tbl[i].ctrl[1:0]});
            chk("tbl_addr", io_addr, tbl[i].addr);
            sc = cyc;
            if (tbl[i].wr) begin
                chk("tbl_wdata", io_dataOut, tbl[i].data);
                for (int k = 0; k < 5; k++) begin
                    tick();
                    chk("tbl_no_rsp", rsp_valid, 64'd0);
                    chk("tbl_single_strobe", io_control[1:0], 64'd0);
                end
            end else begin
                force_en  = 1'b1;
                force_din = tbl[i].core;
                found     = 1'b0;
                for (int k = 0; k < 10 && !found; k++) begin
                    tick();
                    if (io_control[1:0] != 2'b00) chk("tbl_single_strobe", io_control[1:0], 64'd0);
                    if (rsp_valid) found = 1'b1;
                end
                force_en = 1'b0;
                chk("tbl_rsp_seen", found, 64'd1);
                chk("tbl_rsp_latency", 64'(cyc - sc), 64'(LAT + 1));
                chk("tbl_rsp_data", rsp_data, tbl[i].core);
                chk("tbl_halt_resp", io_control[2], 64'(HALT));
                tick();
                tick();
                chk("tbl_halt_release", io_control[2], 64'd0);
            end
        end

        // Fill the queue behind a stalled read response, then drain in order
        rsp_ready = 1'b0;
        push_one(1'b0, 15'h0100, 64'd0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (rsp_valid) found = 1'b1;
        end
        chk("fill_rsp_seen", found, 64'd1);
        wr_log.delete();
        for (int i = 0; i < 5; i++) begin
            fa[i] = 15'(16'h0200 + 16'(i));
            fd[i] = 64'h1111_0000_0000_0000 + 64'(i);
        end
        for (int i = 0; i < 4; i++) push_one(1'b1, fa[i], fd[i]);
        chk("fill_ready_low", req_ready, 64'd0);
        sc = 0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = fa[4];
        req_data  = fd[4];
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("stall_rsp_valid", rsp_valid, 64'd1);
            chk("stall_no_strobe", io_control[1:0], 64'd0);
            chk("stall_ready_low", req_ready, 64'd0);
        end
        rsp_ready = 1'b1;
        push_one(1'b1, fa[4], fd[4]);
        for (int k = 0; k < 30; k++) tick();
        chk("fill_write_count", wr_log.size(), 64'd5);
        for (int i = 0; i < 5 && i < wr_log.size(); i++) begin
            chk("fill_order_addr", wr_log[i].addr, fa[i]);
            chk("fill_order_data", wr_log[i].data, fd[i]);
            if (i > 0) chk("fill_write_spacing", 64'(wr_log[i].cyc - wr_log[i-1].cyc), 64'd2);
        end

        // Reset while a read waits with two writes queued
        wr_log.delete();
        push_one(1'b0, 15'h0123, 64'd0);
        push_one(1'b1, 15'h0456, 64'h77);
        push_one(1'b1, 15'h0789, 64'h88);
        chk("mid_rst_no_rsp_yet", rsp_valid, 64'd0);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_ready", req_ready, 64'd1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("mid_rst_no_strobe", io_control, 64'd0);
            chk("mid_rst_no_rsp", rsp_valid, 64'd0);
            chk("mid_rst_ready_hold", req_ready, 64'd1);
        end
        chk("mid_rst_no_writes", wr_log.size(), 64'd0);

        // Randomized traffic against the queue model
        for (int k = 0; k < 2000; k++) begin
            reset     = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            req_valid = ($urandom_range(0, 2) != 0);
            req_write = $urandom_range(0, 1);
            req_addr  = 15'($urandom);
            req_data  = rnd64();
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 60; k++) tick();
        chk("drain_queue_empty", pend_q.size(), 64'd0);
        chk("drain_no_read", read_busy, 64'd0);
        chk("drain_rsp_consumed", exp_rsp_q.size(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coproc_io_bridge.md
COPROC_IO_BRIDGE -- requirements
Module: coproc_io_bridge

Interface
REQ-001 Parameters SHALL be: N, default 64, data width; FIFO_DEPTH, default 4 (power of two, 2..16), request queue entries; READ_LAT, default 1 (1..4), cycles from read strobe to valid io_dataIn.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 req_valid  in  1  host request valid.
REQ-005 req_ready  out  1  request queue can accept.
REQ-006 req_write  in  1  1=write, 0=read.
REQ-007 req_addr  in  15  coprocessor register address.
REQ-008 req_data  in  N  write data.
REQ-009 rsp_valid  out  1  read response valid.
REQ-010 rsp_ready  in  1  host accepts response.
REQ-011 rsp_data  out  N  read response data.
REQ-012 io_addr  out  15  drives core coprocessorIOAddr.
REQ-013 io_control  out  4  drives core coprocessorIOControl; bit0 read strobe, bit1 write strobe, bit2 core halt, bit3 always 0.
REQ-014 io_dataOut  out  N  drives core coprocessorIODataOut.
REQ-015 io_dataIn  in  N  from core coprocessorIODataIn.

Function
REQ-016 Request accepted on the clk edge where req_valid && req_ready; the request is pushed into a FIFO_DEPTH-entry FIFO.
REQ-017 req_ready SHALL be 1 iff FIFO not full; a pop in the same cycle does not free space for that cycle's push.
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: FIFO non-empty -> pop head, go ISSUE next cycle.
REQ-020 ISSUE (exactly one cycle): io_addr = head addr; write: io_control[1]=1, io_dataOut = head data, next IDLE; read: io_control[0]=1, next WAIT.
REQ-021 Outside ISSUE, io_control[1:0] SHALL be 0, io_addr and io_dataOut hold last issued values.
REQ-022 WAIT: counter loaded with READ_LAT-1 on ISSUE; io_dataIn sampled into rsp_data when counter is 0, then RESP; READ_LAT=1 samples on the cycle after ISSUE.
REQ-023 RESP: rsp_valid=1, rsp_data stable until rsp_valid && rsp_ready; then IDLE.
REQ-024 Responses SHALL return in request order; writes produce no response.
REQ-025 Back-to-back writes SHALL issue one per two cycles (ISSUE, IDLE); no request is issued while a read is in WAIT or RESP.
REQ-026 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full = MSBs differ and low bits equal; empty = pointers equal.
REQ-027 Simultaneous push on empty FIFO and IDLE: request is popped the following cycle (no bypass).

Reset
REQ-028 While reset=0 at a clk edge: FIFO empty, state IDLE, WAIT counter 0, req_ready=0 during reset then 1 on the first cycle after reset=1, rsp_valid=0, rsp_data=0, io_addr=0, io_dataOut=0, io_control=0.
REQ-029 Reset asserted mid-operation SHALL discard queued requests and any pending response with no further io strobes.

Configuration
REQ-030 Macro COPROC_HALT_EN: when defined, io_control[2]=1 from the cycle after the FIFO becomes non-empty until the cycle after the FSM returns to IDLE with FIFO empty; when undefined, io_control[2] is constant 0 and no halt logic exists.

Verification
REQ-031 Single write addr 0x340 data 0xDEAD -> one cycle io_control=0b0010, io_addr=0x340, io_dataOut=0xDEAD; rsp_valid stays 0.
REQ-032 Read addr 0x300, READ_LAT=2, io_dataIn=0x1234 at sample cycle -> io_control=0b0001 for one cycle, rsp_valid=1 with rsp_data=0x1234 three cycles after ISSUE start edge.
REQ-033 Push 5 writes back-to-back, FIFO_DEPTH=4, no pop possible before fill -> req_ready=0 after 4th accept; all 5 issued in order, 5th value last.
REQ-034 Read with rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data held; no further io strobe until handshake.
REQ-035 Reset=0 during WAIT with 2 queued writes -> after release, io_control stays 0, rsp_valid=0, req_ready=1.
REQ-036 With COPROC_HALT_EN, one read -> io_control[2]=1 spanning ISSUE through RESP, 0 two cycles after handshake; without macro, io_control[2]=0 throughout.
